// File: rtl/state_encoder_pkg.sv
// Shared types and elaboration helpers for the serial state encoder.
// Optional parity slot is enabled by defining STATE_ENCODER_PARITY_EN.
package state_encoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_ON,
      ST_HDR_OFF,
      ST_SPACE,
      ST_BIT,
      ST_CLS_SPACE,
      ST_CLS_ON
   } enc_state_e;

`ifdef STATE_ENCODER_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Total cycles that busy is high for one frame.
   function automatic int frame_len(input int sw, input int hon, input int hoff,
                                    input int sp, input int bl, input int con,
                                    input bit par);
      return hon + hoff + (sw + int'(par)) * (sp + bl) + sp + con;
   endfunction

   function automatic bit params_ok(input int sw, input int hon, input int hoff,
                                    input int sp, input int bl, input int con);
      return (sw >= 1) && (sw <= 32) && (hon >= 1) && (hoff >= 1) &&
             (sp >= 1) && (bl >= 1) && (con >= 1);
   endfunction

   function automatic int max_len(input int a, input int b, input int c,
                                  input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/state_encoder_gen_rise.sv
// Registered rising-edge detector; history register resets to RESET_LEVEL.
module sync_rise_detect #(
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) r_q <= RESET_LEVEL;
      else     r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/state_encoder_gen.sv
// Serial state encoder: header, spacer-separated bits, closer, with busy/done.
// Define STATE_ENCODER_PARITY_EN to append an even-parity slot after the last bit.
//
// state        | meaning
// ST_IDLE      | waiting for a rise on enable, out low
// ST_HDR_ON    | header high period
// ST_HDR_OFF   | header low period
// ST_SPACE     | low spacer ahead of a bit slot
// ST_BIT       | driving the current bit (or parity)
// ST_CLS_SPACE | low spacer ahead of the closer
// ST_CLS_ON    | closer high period
module state_encoder_gen
   import state_encoder_pkg::*;
#(
   parameter int STATE_WIDTH = 7,
   parameter int HEADER_ON   = 3,
   parameter int HEADER_OFF  = 3,
   parameter int SPACER_LEN  = 2,
   parameter int BIT_LEN     = 1,
   parameter int CLOSER_ON   = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STATE_WIDTH-1:0] state,
   input  logic                   enable,
   output logic                   out,
   output logic                   busy,
   output logic                   done
);

   localparam int CNT_W = $clog2(max_len(HEADER_ON, HEADER_OFF, SPACER_LEN,
                                         BIT_LEN, CLOSER_ON)) + 1;
   localparam int IDX_W = $clog2(STATE_WIDTH) + 1;
   localparam logic [IDX_W-1:0] IDX_FIRST = MSB_FIRST ? IDX_W'(STATE_WIDTH - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST  = MSB_FIRST ? '0 : IDX_W'(STATE_WIDTH - 1);

   if (!params_ok(STATE_WIDTH, HEADER_ON, HEADER_OFF, SPACER_LEN, BIT_LEN, CLOSER_ON)) begin : g_bad_params
      $error("state_encoder_gen: illegal length parameter or STATE_WIDTH outside 1..32");
   end

   enc_state_e             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [IDX_W-1:0]       r_idx;
   logic [STATE_WIDTH-1:0] r_word;
   logic                   r_par;
   logic                   r_out;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_rise;
   logic                   w_tc;
   logic                   w_last;
   logic                   w_data;
   logic [STATE_WIDTH-1:0] w_shift;

   sync_rise_detect #(.RESET_LEVEL(1'b1)) u_rise (
      .clk    (clk),
      .rst    (rst),
      .i_d    (enable),
      .o_rise (w_rise)
   );

   // Shift instead of a direct index so the wider index counter stays legal.
   assign w_shift = r_word >> r_idx;
   assign w_data  = r_par ? ^r_word : w_shift[0];
   assign w_last  = (r_idx == IDX_LAST);

   always_comb begin
      w_tc = 1'b0;
      case (r_state)
         ST_HDR_ON:    w_tc = (r_cnt == CNT_W'(HEADER_ON - 1));
         ST_HDR_OFF:   w_tc = (r_cnt == CNT_W'(HEADER_OFF - 1));
         ST_SPACE:     w_tc = (r_cnt == CNT_W'(SPACER_LEN - 1));
         ST_BIT:       w_tc = (r_cnt == CNT_W'(BIT_LEN - 1));
         ST_CLS_SPACE: w_tc = (r_cnt == CNT_W'(SPACER_LEN - 1));
         ST_CLS_ON:    w_tc = (r_cnt == CNT_W'(CLOSER_ON - 1));
         default:      w_tc = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_word  <= '0;
         r_par   <= 1'b0;
         r_out   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_word  <= state;
                  r_idx   <= IDX_FIRST;
                  r_par   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_HDR_ON;
                  r_out   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_HDR_ON: begin
               if (w_tc) begin
                  r_state <= ST_HDR_OFF;
                  r_out   <= 1'b0;
               end
            end
            ST_HDR_OFF: begin
               if (w_tc) r_state <= ST_SPACE;
            end
            ST_SPACE: begin
               if (w_tc) begin
                  r_state <= ST_BIT;
                  r_out   <= w_data;
               end
            end
            ST_BIT: begin
               if (w_tc) begin
                  r_out <= 1'b0;
                  if (r_par || (w_last && !PARITY_EN)) begin
                     r_state <= ST_CLS_SPACE;
                  end else begin
                     r_state <= ST_SPACE;
                     if (w_last)         r_par <= 1'b1;
                     else if (MSB_FIRST) r_idx <= r_idx - 1'b1;
                     else                r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_CLS_SPACE: begin
               if (w_tc) begin
                  r_state <= ST_CLS_ON;
                  r_out   <= 1'b1;
               end
            end
            ST_CLS_ON: begin
               if (w_tc) begin
                  r_state <= ST_IDLE;
                  r_out   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_state_encoder_gen.sv
// Directed/random bench for state_encoder_gen with a waveform-list reference model.
module tb_state_encoder_gen;
   import state_encoder_pkg::*;

`ifdef STATE_ENCODER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   // second instance: narrow word, LSB first, non-default timing
   localparam int B_SW = 4, B_HON = 2, B_HOFF = 1, B_SP = 1, B_BL = 2, B_CON = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en0 = 1'b0, en1 = 1'b0;
   logic [6:0] st0 = '0;
   logic [3:0] st1 = '0;
   logic       out0, busy0, done0, out1, busy1, done1;

   int          tests = 0;
   int          fails = 0;
   bit          exp_q[$];
   bit          armed = 1'b0;
   logic [31:0] next_word;

   always #5 clk = ~clk;

   state_encoder_gen u_dut0 (
      .clk(clk), .rst(rst), .state(st0), .enable(en0),
      .out(out0), .busy(busy0), .done(done0)
   );

   state_encoder_gen #(
      .STATE_WIDTH(B_SW), .HEADER_ON(B_HON), .HEADER_OFF(B_HOFF),
      .SPACER_LEN(B_SP), .BIT_LEN(B_BL), .CLOSER_ON(B_CON), .MSB_FIRST(1'b0)
   ) u_dut1 (
      .clk(clk), .rst(rst), .state(st1), .enable(en1),
      .out(out1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic get_cfg(input int sel, output int sw, output int hon, output int hoff,
                          output int sp, output int bl, output int con, output bit msb);
      if (sel == 0) begin
         sw = 7; hon = 3; hoff = 3; sp = 2; bl = 1; con = 2; msb = 1'b1;
      end else begin
         sw = B_SW; hon = B_HON; hoff = B_HOFF; sp = B_SP; bl = B_BL; con = B_CON; msb = 1'b0;
      end
   endtask

   // Expected out level for every busy cycle, straight from the frame rules.
   task automatic build(input int sel, input logic [31:0] word, output int f);
      int sw, hon, hoff, sp, bl, con;
      bit msb, b, p;
      get_cfg(sel, sw, hon, hoff, sp, bl, con, msb);
      exp_q.delete();
      p = 1'b0;
      repeat (hon)  exp_q.push_back(1'b1);
      repeat (hoff) exp_q.push_back(1'b0);
      for (int i = 0; i < sw; i++) begin
         b = msb ? word[sw-1-i] : word[i];
         p = p ^ b;
         repeat (sp) exp_q.push_back(1'b0);
         repeat (bl) exp_q.push_back(b);
      end
      if (PAR) begin
         repeat (sp) exp_q.push_back(1'b0);
         repeat (bl) exp_q.push_back(p);
      end
      repeat (sp)  exp_q.push_back(1'b0);
      repeat (con) exp_q.push_back(1'b1);
      f = frame_len(sw, hon, hoff, sp, bl, con, PAR);
   endtask

   task automatic set_en(input int sel, input logic v);
      if (sel == 0) en0 = v; else en1 = v;
   endtask

   task automatic set_state(input int sel, input logic [31:0] w);
      if (sel == 0) st0 = w[6:0]; else st1 = w[3:0];
   endtask

   task automatic sample(input int sel, output logic o, output logic b, output logic d);
      if (sel == 0) begin o = out0; b = busy0; d = done0; end
      else          begin o = out1; b = busy1; d = done1; end
   endtask

   // mode: 0 normal, 1 hold enable high, 2 mid-frame rise + state change,
   //       3 reset abort mid-frame, 4 chain a new rise into the done cycle
   task automatic run_frame(input int sel, input logic [31:0] word, input int mode);
      int f;
      logic o, b, d;
      build(sel, word, f);
      if (!armed) begin
         set_en(sel, 1'b0);
         step();
         set_state(sel, word);
         set_en(sel, 1'b1);
      end
      armed = 1'b0;
      step();
      for (int k = 0; k < f; k++) begin
         sample(sel, o, b, d);
         check($sformatf("s%0d m%0d out[%0d]", sel, mode, k), 32'(o), 32'(exp_q[k]));
         check($sformatf("s%0d m%0d busy[%0d]", sel, mode, k), 32'(b), 32'd1);
         check($sformatf("s%0d m%0d done[%0d]", sel, mode, k), 32'(d), 32'd0);
         if (mode == 3 && k == 14) begin
            rst = 1'b1;
            set_en(sel, 1'b0);
            step();
            rst = 1'b0;
            sample(sel, o, b, d);
            check("abort out", 32'(o), 32'd0);
            check("abort busy", 32'(b), 32'd0);
            check("abort done", 32'(d), 32'd0);
            for (int j = 0; j < 4; j++) begin
               step();
               sample(sel, o, b, d);
               check($sformatf("post-abort busy[%0d]", j), 32'(b), 32'd0);
               check($sformatf("post-abort done[%0d]", j), 32'(d), 32'd0);
            end
            return;
         end
         if (k == 0 && mode != 1) set_en(sel, 1'b0);
         if (mode == 2 && k == 5) set_state(sel, ~word);
         if (mode == 2 && k == 9) set_en(sel, 1'b1);
         step();
      end
      sample(sel, o, b, d);
      check($sformatf("s%0d m%0d end out", sel, mode), 32'(o), 32'd0);
      check($sformatf("s%0d m%0d end busy", sel, mode), 32'(b), 32'd0);
      check($sformatf("s%0d m%0d end done", sel, mode), 32'(d), 32'd1);
      if (mode == 4) begin
         set_state(sel, next_word);
         set_en(sel, 1'b1);
         armed = 1'b1;
         return;
      end
      for (int j = 0; j < 3; j++) begin
         step();
         sample(sel, o, b, d);
         check($sformatf("s%0d m%0d idle busy[%0d]", sel, mode, j), 32'(b), 32'd0);
         check($sformatf("s%0d m%0d idle done[%0d]", sel, mode, j), 32'(d), 32'd0);
         check($sformatf("s%0d m%0d idle out[%0d]", sel, mode, j), 32'(o), 32'd0);
      end
      set_en(sel, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (3) step();
      check("rst out0", 32'(out0), 32'd0);
      check("rst busy0", 32'(busy0), 32'd0);
      check("rst done0", 32'(done0), 32'd0);
      check("rst out1", 32'(out1), 32'd0);
      check("rst busy1", 32'(busy1), 32'd0);
      rst = 1'b0;
      step();

      // basic frame, MSB first
      run_frame(0, 32'b1010011, 0);

      // LSB first, narrow instance
      run_frame(1, 32'b0001, 0);
      repeat (3) run_frame(1, $urandom, 0);

      // rise and state change mid-frame are ignored
      run_frame(0, $urandom, 2);

      // enable held high through reset release never triggers
      en0 = 1'b1;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         check($sformatf("held-high busy[%0d]", i), 32'(busy0), 32'd0);
      end
      run_frame(0, $urandom, 1);

      // reset mid-frame, then a fresh complete frame
      run_frame(0, $urandom, 3);
      run_frame(0, $urandom, 0);

      // rise accepted in the done cycle
      next_word = $urandom;
      run_frame(0, $urandom, 4);
      run_frame(0, next_word, 0);

      // parity-sensitive words, then random coverage
      run_frame(0, 32'b1010011, 0);
      run_frame(0, 32'b0000001, 0);
      repeat (4) run_frame(0, $urandom, 0);
      repeat (2) run_frame(1, $urandom, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
